cnt_sched: RTL and testbench
============================

CNT_SCHED -- requirements
Module: cnt_sched

Interface
REQ-001 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-002 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-003 SHALL have ports reqN_valid, input, 1 bit, N=0,1: requester N presents a command.
REQ-004 SHALL have ports reqN_up, input, 1 bit: direction; 1 = count up, 0 = count down.
REQ-005 SHALL have ports reqN_len, input, 4 bits: number of count steps, 0..15.
REQ-006 SHALL have ports reqN_ready, output, 1 bit: command of requester N accepted this cycle.
REQ-007 SHALL have port clr, input, 1 bit: request to zero the shared counter.
REQ-008 SHALL have port count, output, 4 bits: current shared counter value.
REQ-009 SHALL have port busy, output, 1 bit: a command is in progress (state not IDLE).
REQ-010 SHALL have port done, output, 1 bit: one-cycle completion pulse.
REQ-011 SHALL have port done_id, output, 1 bit: requester whose command completed; valid only when done=1.

Function
REQ-012 SHALL implement states IDLE, RUN and DONE.
REQ-013 In IDLE with clr=1, SHALL zero count at the next edge, assert no reqN_ready, and stay in IDLE; clr has priority over requests.
REQ-014 SHALL ignore clr outside IDLE.
REQ-015 In IDLE with clr=0 and exactly one reqN_valid, SHALL assert that reqN_ready combinationally in the same cycle.
REQ-016 In IDLE with clr=0 and both valid, SHALL grant the requester not served most recently (round-robin); requester 0 wins the first tie after reset.
REQ-017 SHALL assert at most one reqN_ready per cycle, and only in IDLE.
REQ-018 On acceptance, SHALL latch direction, length and requester id.
REQ-019 On acceptance, SHALL update the round-robin pointer to the granted requester.
REQ-020 On acceptance with len>0, SHALL enter RUN; with len=0, SHALL enter DONE directly and leave count unchanged.
REQ-021 In RUN, SHALL step count by exactly one per cycle in the latched direction, for exactly len cycles.
REQ-022 After the last step, SHALL enter DONE.
REQ-023 Count arithmetic SHALL be modulo 16: 15+1 -> 0, 0-1 -> 15.
REQ-024 In DONE, SHALL assert done=1 for exactly one cycle with done_id = latched id and count holding the final value, then return to IDLE.
REQ-025 A command accepted at edge T with len=L SHALL produce done in cycle T+L+1 (T+1 for L=0).
REQ-026 count SHALL hold its value in IDLE (clr=0) and in DONE.
REQ-027 Requester inputs SHALL be don't-care while busy=1; no queuing.
REQ-028 A new command SHALL be accepted no earlier than the cycle after DONE.

Reset
REQ-029 On rst=1 at a clock edge, regardless of state, SHALL set: state IDLE, count 0, busy 0, done 0, done_id 0, reqN_ready 0, round-robin pointer favouring requester 0.
REQ-030 rst SHALL override clr and any in-flight command; an aborted command SHALL produce no done.

Structure
REQ-031 Shared package cnt_sched_pkg SHALL hold: state enum, CNT_W=4, LEN_W=4, N_REQ=2.
REQ-032 The counter datapath SHALL be the existing counter1 instance (rst, clk, en, udbar, cnt).
REQ-033 The scheduler SHALL drive counter1 as follows: en=1 only in RUN, udbar = latched direction, counter reset = rst OR (IDLE and clr).
REQ-034 count SHALL be the counter1 cnt output, unregistered.

Verification
REQ-035 Reset then req0 up len=5 -> req0_ready in the accept cycle; count 1,2,3,4,5; done in cycle T+6 with done_id=0, count=5.
REQ-036 count=14, req1 up len=4 -> count 15,0,1,2; done_id=1 with count=2.
REQ-037 count=0, req0 down len=0 -> done at T+1; count stays 0; busy high exactly 1 cycle.
REQ-038 Both valid in consecutive IDLE windows, len=1 each -> grants alternate 0,1,0,1; never both ready in one cycle.
REQ-039 clr=1 with req0_valid=1 in IDLE, count=9 -> count=0 next cycle and no ready; with clr=1 during RUN -> ignored, count continues.
REQ-040 rst asserted mid-RUN of len=10 -> next cycle IDLE, count=0, no done pulse; a subsequent tie grants requester 0.

Source files
------------

// File: rtl/cnt_sched_pkg.sv
// Shared types and sizes for the two-requester counter scheduler.
// Imported by the interface, the scheduler top and the counter datapath.
package cnt_sched_pkg;

    localparam int CNT_W = 4;
    localparam int LEN_W = 4;
    localparam int N_REQ = 2;
    localparam int ID_W  = 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/cnt_sched_if.sv
// Command/status bundle between the requesters and cnt_sched.
// The requester side uses master; the scheduler uses slave.
interface cnt_sched_if;
    import cnt_sched_pkg::*;

    logic             req0_valid;
    logic             req0_up;
    logic [LEN_W-1:0] req0_len;
    logic             req0_ready;
    logic             req1_valid;
    logic             req1_up;
    logic [LEN_W-1:0] req1_len;
    logic             req1_ready;
    logic             clr;
    logic [CNT_W-1:0] count;
    logic             busy;
    logic             done;
    logic             done_id;

    modport master (
        output req0_valid, req0_up, req0_len,
        output req1_valid, req1_up, req1_len,
        output clr,
        input  req0_ready, req1_ready, count, busy, done, done_id
    );

    modport slave (
        input  req0_valid, req0_up, req0_len,
        input  req1_valid, req1_up, req1_len,
        input  clr,
        output req0_ready, req1_ready, count, busy, done, done_id
    );

endinterface

// File: rtl/cnt_sched_counter1.sv
// counter1: wrapping up/down counter with synchronous active-high reset.
// udbar=1 counts up, udbar=0 counts down; holds when en=0.
module counter1
    import cnt_sched_pkg::*;
(
    input  logic             rst,
    input  logic             clk,
    input  logic             en,
    input  logic             udbar,
    output logic [CNT_W-1:0] cnt
);

    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (en) cnt_d = udbar ? cnt_q + CNT_W'(1) : cnt_q - CNT_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/cnt_sched.sv
// Two-requester round-robin scheduler that runs count commands on a shared
// counter1 instance, one command at a time, with a one-cycle done pulse.
module cnt_sched
    import cnt_sched_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    cnt_sched_if.slave   bus
);

    state_t                        state_q, state_d;
    logic                          up_q, up_d;
    logic [LEN_W-1:0]              rem_q, rem_d;
    logic [ID_W-1:0]               id_q, id_d;
    logic [ID_W-1:0]               last_q, last_d;
    logic                          busy_q, busy_d;
    logic                          done_q, done_d;
    logic [ID_W-1:0]               done_id_q, done_id_d;

    logic [N_REQ-1:0]              vld;
    logic [N_REQ-1:0]              dir;
    logic [N_REQ-1:0][LEN_W-1:0]   len;
    logic [N_REQ-1:0]              gnt;
    logic [ID_W-1:0]               gid;
    logic                          idle_open;
    logic                          cnt_rst;
    logic                          cnt_en;

    assign vld = {bus.req1_valid, bus.req0_valid};
    assign dir = {bus.req1_up,    bus.req0_up};
    assign len = {bus.req1_len,   bus.req0_len};

    // last_q holds the most recently served requester; a tie goes to the other.
    assign idle_open = (state_q == IDLE) && !bus.clr;
    assign gnt[0]    = idle_open && vld[0] && (!vld[1] || last_q == ID_W'(1));
    assign gnt[1]    = idle_open && vld[1] && (!vld[0] || last_q == ID_W'(0));
    assign gid       = gnt[1] ? ID_W'(1) : ID_W'(0);

    assign bus.req0_ready = gnt[0];
    assign bus.req1_ready = gnt[1];

    always_comb begin
        state_d = state_q;
        up_d    = up_q;
        rem_d   = rem_q;
        id_d    = id_q;
        last_d  = last_q;
        case (state_q)
            IDLE: begin
                if (|gnt) begin
                    up_d    = dir[gid];
                    rem_d   = len[gid];
                    id_d    = gid;
                    last_d  = gid;
                    state_d = (len[gid] == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                rem_d = rem_q - LEN_W'(1);
                if (rem_q == LEN_W'(1)) state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d    = (state_d != IDLE);
        done_d    = (state_d == DONE);
        done_id_d = (state_d == DONE) ? id_d : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            up_q      <= 1'b0;
            rem_q     <= '0;
            id_q      <= '0;
            last_q    <= ID_W'(1);
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            state_q   <= state_d;
            up_q      <= up_d;
            rem_q     <= rem_d;
            id_q      <= id_d;
            last_q    <= last_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            done_id_q <= done_id_d;
        end
    end

    // clr only zeroes the counter while idle; in RUN/DONE it has no effect.
    assign cnt_rst = rst || ((state_q == IDLE) && bus.clr);
    assign cnt_en  = (state_q == RUN);

    counter1 u_counter1 (
        .rst   (cnt_rst),
        .clk   (clk),
        .en    (cnt_en),
        .udbar (up_q),
        .cnt   (bus.count)
    );

    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.done_id = done_id_q;

endmodule

// File: tb/tb_cnt_sched.sv
// Directed bench for cnt_sched: reset, runs, wrap, zero-length, round-robin,
// clr priority/ignore and mid-run reset, all with hand-computed values.
module tb_cnt_sched;
    import cnt_sched_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    cnt_sched_if bus ();

    cnt_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_tests++;
        assert (got === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive(input int id, input logic v, input logic up, input logic [3:0] len);
        if (id == 0) begin
            bus.req0_valid = v; bus.req0_up = up; bus.req0_len = len;
        end else begin
            bus.req1_valid = v; bus.req1_up = up; bus.req1_len = len;
        end
    endtask

    // Issue one command from an idle state starting at count 'start' and
    // follow it through every cycle up to the return to IDLE.
    task automatic cmd(input string tag, input int id, input logic up,
                       input int len, input logic [3:0] start);
        logic [3:0] e;
        e = start;
        drive(id, 1'b1, up, 4'(len));
        #1;
        chk({tag, "_rdy0"}, 8'(bus.req0_ready), 8'(id == 0));
        chk({tag, "_rdy1"}, 8'(bus.req1_ready), 8'(id == 1));
        step();
        drive(id, 1'b0, 1'b0, 4'd0);
        chk({tag, "_busy"}, 8'(bus.busy), 8'd1);
        chk({tag, "_done0"}, 8'(bus.done), 8'(len == 0));
        for (int k = 1; k <= len; k++) begin
            step();
            e = up ? e + 4'd1 : e - 4'd1;
            chk({tag, "_cnt"}, 8'(bus.count), 8'(e));
            chk({tag, "_done"}, 8'(bus.done), 8'(k == len));
        end
        chk({tag, "_done_id"}, 8'(bus.done_id), 8'(id));
        chk({tag, "_final"}, 8'(bus.count), 8'(e));
        step();
        chk({tag, "_idle_busy"}, 8'(bus.busy), 8'd0);
        chk({tag, "_idle_done"}, 8'(bus.done), 8'd0);
        chk({tag, "_idle_cnt"}, 8'(bus.count), 8'(e));
    endtask

    initial begin
        bus.clr = 1'b0;
        drive(0, 1'b0, 1'b0, 4'd0);
        drive(1, 1'b0, 1'b0, 4'd0);
        step();
        step();
        rst = 1'b0;
        chk("rst_count", 8'(bus.count), 8'd0);
        chk("rst_busy", 8'(bus.busy), 8'd0);
        chk("rst_done", 8'(bus.done), 8'd0);
        chk("rst_done_id", 8'(bus.done_id), 8'd0);
        chk("rst_rdy", 8'({bus.req1_ready, bus.req0_ready}), 8'd0);

        // Basic run, then climb to 14 and wrap through 15 -> 0.
        cmd("up5", 0, 1'b1, 5, 4'd0);
        cmd("to14", 1, 1'b1, 9, 4'd5);
        cmd("wrap", 1, 1'b1, 4, 4'd14);

        // Round-robin: last served was 1, so ties go 0,1,0,1.
        drive(0, 1'b1, 1'b1, 4'd1);
        drive(1, 1'b1, 1'b1, 4'd1);
        for (int r = 0; r < 4; r++) begin
            #1;
            chk("rr_rdy0", 8'(bus.req0_ready), 8'(r % 2 == 0));
            chk("rr_rdy1", 8'(bus.req1_ready), 8'(r % 2 == 1));
            step();
            chk("rr_run_rdy", 8'({bus.req1_ready, bus.req0_ready}), 8'd0);
            step();
            chk("rr_done", 8'(bus.done), 8'd1);
            chk("rr_done_id", 8'(bus.done_id), 8'(r % 2));
            chk("rr_done_rdy", 8'({bus.req1_ready, bus.req0_ready}), 8'd0);
            chk("rr_cnt", 8'(bus.count), 8'(3 + r));
            step();
        end
        drive(0, 1'b0, 1'b0, 4'd0);
        drive(1, 1'b0, 1'b0, 4'd0);

        // clr wins over a request in IDLE.
        cmd("to9", 0, 1'b1, 3, 4'd6);
        bus.clr = 1'b1;
        drive(0, 1'b1, 1'b1, 4'd3);
        #1;
        chk("clr_no_rdy", 8'(bus.req0_ready), 8'd0);
        step();
        bus.clr = 1'b0;
        drive(0, 1'b0, 1'b0, 4'd0);
        chk("clr_count", 8'(bus.count), 8'd0);
        chk("clr_busy", 8'(bus.busy), 8'd0);

        // Zero-length command, then 0-1 wraps to 15.
        cmd("len0", 0, 1'b0, 0, 4'd0);
        cmd("dn_wrap", 0, 1'b0, 1, 4'd0);

        // clr during RUN is ignored.
        drive(0, 1'b1, 1'b1, 4'd3);
        step();
        drive(0, 1'b0, 1'b0, 4'd0);
        bus.clr = 1'b1;
        step();
        chk("clr_run_c1", 8'(bus.count), 8'd0);
        step();
        chk("clr_run_c2", 8'(bus.count), 8'd1);
        step();
        chk("clr_run_c3", 8'(bus.count), 8'd2);
        chk("clr_run_done", 8'(bus.done), 8'd1);
        bus.clr = 1'b0;
        step();

        // Reset mid-run of len=10: no done afterwards, tie then goes to 0.
        drive(1, 1'b1, 1'b1, 4'd10);
        step();
        drive(1, 1'b0, 1'b0, 4'd0);
        for (int k = 0; k < 4; k++) step();
        chk("pre_rst_cnt", 8'(bus.count), 8'd6);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_cnt", 8'(bus.count), 8'd0);
        chk("mid_rst_busy", 8'(bus.busy), 8'd0);
        for (int k = 0; k < 10; k++) begin
            step();
            chk("mid_rst_nodone", 8'(bus.done), 8'd0);
        end
        drive(0, 1'b1, 1'b1, 4'd1);
        drive(1, 1'b1, 1'b1, 4'd1);
        #1;
        chk("post_rst_tie", 8'({bus.req1_ready, bus.req0_ready}), 8'd1);
        step();
        drive(0, 1'b0, 1'b0, 4'd0);
        drive(1, 1'b0, 1'b0, 4'd0);
        step();
        chk("post_rst_done_id", 8'(bus.done_id), 8'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
